// File: rtl/egg_timer_pkg.sv
// Shared types and constants for the egg-timer engine: FSM states, default tick rate,
// seven-segment patterns and the BCD preset clamp.
package egg_timer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StPause,
    StDone
  } state_e;

  localparam int unsigned DefaultTicksPerSec = 50_000_000;

  // Active-low segments, bit 6 = g ... bit 0 = a
  localparam logic [6:0] Seg0     = 7'b1000000;
  localparam logic [6:0] Seg1     = 7'b1111001;
  localparam logic [6:0] Seg2     = 7'b0100100;
  localparam logic [6:0] Seg3     = 7'b0110000;
  localparam logic [6:0] Seg4     = 7'b0011001;
  localparam logic [6:0] Seg5     = 7'b0010010;
  localparam logic [6:0] Seg6     = 7'b0000010;
  localparam logic [6:0] Seg7     = 7'b1111000;
  localparam logic [6:0] Seg8     = 7'b0000000;
  localparam logic [6:0] Seg9     = 7'b0010000;
  localparam logic [6:0] SegBlank = 7'b1111111;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] digit, input logic [3:0] limit);
    return (digit > limit) ? limit : digit;
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// BCD digit to active-low seven-segment pattern; non-BCD codes are blanked.
module seven_seg_decoder
  import egg_timer_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SegBlank;
    case (bcd)
      4'd0:    seg = Seg0;
      4'd1:    seg = Seg1;
      4'd2:    seg = Seg2;
      4'd3:    seg = Seg3;
      4'd4:    seg = Seg4;
      4'd5:    seg = Seg5;
      4'd6:    seg = Seg6;
      4'd7:    seg = Seg7;
      4'd8:    seg = Seg8;
      4'd9:    seg = Seg9;
      default: seg = SegBlank;
    endcase
  end

endmodule

// File: rtl/egg_timer_core.sv
// MM:SS BCD countdown engine: key conditioning, prescaler, run/pause/done FSM and
// seven-segment / LED drive for the board top level.
module egg_timer_core
  import egg_timer_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = DefaultTicksPerSec
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] SW,
  input  logic [2:0] KEY,
  output logic [9:0] LEDR,
  output logic [6:0] HEX3,
  output logic [6:0] HEX2,
  output logic [6:0] HEX1,
  output logic [6:0] HEX0
);

  localparam int unsigned PrescW = $clog2(TICKS_PER_SEC);
  localparam logic [PrescW-1:0] PrescMax = PrescW'(TICKS_PER_SEC - 1);

  logic [2:0]        key_meta, key_sync, key_prev;
  logic [1:0]        settle;
  state_e            state;
  logic [PrescW-1:0] presc;
  logic              flash;
  logic [3:0]        min_tens, min_ones, sec_tens, sec_ones;

  logic [2:0] press;
  logic       go, load_min, load_sec, load_ok, tick, time_zero;
  logic       borrow_s0, borrow_s1, borrow_m0, dec_zero;
  logic [3:0] dec_min_tens, dec_min_ones, dec_sec_tens, dec_sec_ones;

  // The chain comes out of reset at 1, so a key held through reset would otherwise
  // look like a fresh press; pulses stay masked until the chain holds real samples.
  assign press    = (settle == 2'd3) ? (key_prev & ~key_sync) : 3'b000;
  assign go       = press[0];
  assign load_min = press[2] & ~press[0];
  assign load_sec = press[1] & ~press[2] & ~press[0];
  assign load_ok  = (state == StIdle) || (state == StPause);
  assign tick     = (presc == PrescMax);

  assign time_zero = ({min_tens, min_ones, sec_tens, sec_ones} == 16'h0000);

  assign borrow_s0    = (sec_ones == 4'd0);
  assign borrow_s1    = borrow_s0 && (sec_tens == 4'd0);
  assign borrow_m0    = borrow_s1 && (min_ones == 4'd0);
  assign dec_sec_ones = borrow_s0 ? 4'd9 : sec_ones - 4'd1;
  assign dec_sec_tens = !borrow_s0 ? sec_tens : ((sec_tens == 4'd0) ? 4'd5 : sec_tens - 4'd1);
  assign dec_min_ones = !borrow_s1 ? min_ones : ((min_ones == 4'd0) ? 4'd9 : min_ones - 4'd1);
  assign dec_min_tens = borrow_m0 ? min_tens - 4'd1 : min_tens;
  assign dec_zero     = ({dec_min_tens, dec_min_ones, dec_sec_tens, dec_sec_ones} == 16'h0000);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      key_meta <= 3'b111;
      key_sync <= 3'b111;
      key_prev <= 3'b111;
      settle   <= 2'd0;
      state    <= StIdle;
      presc    <= '0;
      flash    <= 1'b0;
      min_tens <= 4'd0;
      min_ones <= 4'd0;
      sec_tens <= 4'd0;
      sec_ones <= 4'd0;
    end else begin
      key_meta <= KEY;
      key_sync <= key_meta;
      key_prev <= key_sync;
      if (settle != 2'd3) settle <= settle + 2'd1;

      if (state == StIdle) begin
        presc <= '0;
      end else if (state != StPause) begin
        presc <= tick ? '0 : presc + PrescW'(1);
      end

      if (load_ok && load_min) begin
        min_tens <= clamp_bcd(SW[7:4], 4'd9);
        min_ones <= clamp_bcd(SW[3:0], 4'd9);
      end else if (load_ok && load_sec) begin
        sec_tens <= clamp_bcd(SW[7:4], 4'd5);
        sec_ones <= clamp_bcd(SW[3:0], 4'd9);
      end

      unique case (state)
        StIdle: begin
          if (go && !time_zero) state <= StRun;
        end
        StRun: begin
          if (go) begin
            state <= StPause;
          end else if (tick) begin
            min_tens <= dec_min_tens;
            min_ones <= dec_min_ones;
            sec_tens <= dec_sec_tens;
            sec_ones <= dec_sec_ones;
            if (dec_zero) begin
              state <= StDone;
              flash <= 1'b1;
            end
          end
        end
        StPause: begin
          if (go) state <= StRun;
        end
        StDone: begin
          if (go) begin
            state <= StIdle;
            flash <= 1'b0;
          end else if (tick) begin
            flash <= ~flash;
          end
        end
      endcase
    end
  end

  always_comb begin
    LEDR = 10'h000;
    unique case (state)
      StIdle:  LEDR = 10'h000;
      StRun:   LEDR = 10'h001;
      StPause: LEDR = 10'h002;
      StDone:  LEDR = flash ? 10'h3FF : 10'h000;
    endcase
  end

  seven_seg_decoder u_hex3 (.bcd(min_tens), .seg(HEX3));
  seven_seg_decoder u_hex2 (.bcd(min_ones), .seg(HEX2));
  seven_seg_decoder u_hex1 (.bcd(sec_tens), .seg(HEX1));
  seven_seg_decoder u_hex0 (.bcd(sec_ones), .seg(HEX0));

endmodule

// File: tb/tb_egg_timer_core.sv
// Directed bench for egg_timer_core with a 4-cycle second; expected display and LED
// values are hand-computed per step.
module tb_egg_timer_core;

  localparam int unsigned Ticks = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sw;
  logic [2:0] key;
  logic [9:0] ledr;
  logic [6:0] hex3, hex2, hex1, hex0;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  egg_timer_core #(.TICKS_PER_SEC(Ticks)) dut (
    .CLOCK_50(clk),
    .reset   (reset),
    .SW      (sw),
    .KEY     (key),
    .LEDR    (ledr),
    .HEX3    (hex3),
    .HEX2    (hex2),
    .HEX1    (hex1),
    .HEX0    (hex0)
  );

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [27:0] disp(input logic [15:0] t);
    return {seg_of(t[15:12]), seg_of(t[11:8]), seg_of(t[7:4]), seg_of(t[3:0])};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic check_disp(input string tag, input logic [15:0] t, input logic [9:0] led);
    check({tag, "/hex"}, 32'({hex3, hex2, hex1, hex0}), 32'(disp(t)));
    check({tag, "/led"}, 32'(ledr), 32'(led));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Key low for three edges: the action lands on the third edge.
  task automatic press(input logic [2:0] mask);
    key = key & ~mask;
    cyc(3);
    key = 3'b111;
  endtask

  initial begin
    reset = 1'b1;
    sw    = 8'h00;
    key   = 3'b111;
    cyc(2);
    check_disp("reset", 16'h0000, 10'h000);
    reset = 1'b0;
    cyc(3);

    // Loads and clamping in IDLE
    sw = 8'h27; press(3'b010); check_disp("load_sec", 16'h0027, 10'h000);
    cyc(1); sw = 8'h01; press(3'b100); check_disp("load_min", 16'h0127, 10'h000);
    cyc(1); sw = 8'hFF; press(3'b010); check_disp("clamp_sec", 16'h0159, 10'h000);
    cyc(1); sw = 8'hFF; press(3'b100); check_disp("clamp_min", 16'h9959, 10'h000);
    cyc(1); sw = 8'h01; press(3'b100);
    cyc(1); sw = 8'h00; press(3'b010); check_disp("load_0100", 16'h0100, 10'h000);

    // Run with full borrow chain, then count down to DONE
    cyc(1); press(3'b001); check_disp("start", 16'h0100, 10'h001);
    cyc(3); check_disp("pre_tick", 16'h0100, 10'h001);
    cyc(1); check_disp("borrow", 16'h0059, 10'h001);
    cyc(224); check_disp("run_56s", 16'h0003, 10'h001);
    cyc(4); check_disp("run_02", 16'h0002, 10'h001);
    cyc(4); check_disp("run_01", 16'h0001, 10'h001);
    cyc(4); check_disp("done", 16'h0000, 10'h3FF);
    cyc(3); check_disp("flash_hold", 16'h0000, 10'h3FF);
    cyc(1); check_disp("flash_off", 16'h0000, 10'h000);
    cyc(4); check_disp("flash_on", 16'h0000, 10'h3FF);
    press(3'b001); check_disp("ack", 16'h0000, 10'h000);

    // Pause preserves the fraction of the second
    cyc(1); sw = 8'h30; press(3'b010); check_disp("load_30", 16'h0030, 10'h000);
    cyc(1); press(3'b001); check_disp("start2", 16'h0030, 10'h001);
    cyc(3); press(3'b001); check_disp("pause", 16'h0029, 10'h002);
    cyc(20); check_disp("paused_hold", 16'h0029, 10'h002);
    cyc(1); sw = 8'h45; press(3'b010); check_disp("pause_load", 16'h0045, 10'h002);
    cyc(1); press(3'b001); check_disp("resume", 16'h0045, 10'h001);
    cyc(1); check_disp("resume_1", 16'h0045, 10'h001);
    cyc(1); check_disp("resume_2", 16'h0044, 10'h001);
    sw = 8'h12; press(3'b010); check_disp("run_load_ign", 16'h0044, 10'h001);
    cyc(2); check_disp("run_43", 16'h0043, 10'h001);
    press(3'b001); check_disp("pause_vs_tick", 16'h0043, 10'h002);

    // Reset from PAUSE, start at zero, priority of KEY[0] over KEY[2]
    reset = 1'b1; cyc(1); check_disp("reset_pause", 16'h0000, 10'h000);
    reset = 1'b0; cyc(3);
    press(3'b001); check_disp("start_zero", 16'h0000, 10'h000);
    cyc(1); sw = 8'h05; press(3'b010); check_disp("load_05", 16'h0005, 10'h000);
    cyc(1); sw = 8'h07; press(3'b101); check_disp("go_wins", 16'h0005, 10'h001);

    // Reset mid-run at 00:37, then a key held through reset release
    cyc(1); press(3'b001); check_disp("pause_05", 16'h0005, 10'h002);
    cyc(1); sw = 8'h37; press(3'b010);
    cyc(1); press(3'b001); check_disp("run_37", 16'h0037, 10'h001);
    cyc(1); reset = 1'b1; cyc(1); check_disp("reset_run", 16'h0000, 10'h000);
    sw = 8'h21; key = 3'b101; cyc(2);
    reset = 1'b0; cyc(8); check_disp("held_key", 16'h0000, 10'h000);
    key = 3'b111; cyc(2);
    press(3'b010); check_disp("load_after", 16'h0021, 10'h000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/egg_timer_core.md
# egg_timer_core

Countdown egg-timer engine for the DE-board top level. It consumes the board switches and push-buttons, keeps an MM:SS BCD countdown, and drives the four seven-segment digits and the red LEDs. It is the responder behind `OnBoard`'s pin interface: it owns the state that the board-level bench stimulates through SW/KEY and checks through HEX/LEDR.

## Interface
- `TICKS_PER_SEC`, default 50_000_000: CLOCK_50 cycles per countdown second; must be ≥2.
- `CLOCK_50`  in  1  system clock; the block's only clock.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of CLOCK_50.
- `SW`  in  8  preset value; SW[7:4] is the tens BCD digit, SW[3:0] the ones BCD digit.
- `KEY`  in  3  active-low push-buttons, asynchronous to CLOCK_50. KEY[0] is start/pause/ack, KEY[1] loads seconds, KEY[2] loads minutes.
- `LEDR`  out  10  status and alarm LEDs.
- `HEX3`, `HEX2`  out  7 each  minutes tens and minutes ones; active-low segments, bit 6 = g … bit 0 = a.
- `HEX1`, `HEX0`  out  7 each  seconds tens and seconds ones; same encoding.

## Operation
- Key conditioning:
  - Each KEY bit passes through a 2-flop synchronizer and then a previous-value flop.
  - A press is a sync 1→0 transition. It produces a 1-cycle pulse. Holding the key produces no further pulses.
- Time registers: four BCD digits, m1 m0 : s1 s0. Range is 00:00 to 99:59.
- Load rules (accepted only in IDLE or PAUSE; ignored in RUN and DONE):
  - KEY[1] loads s1 = min(SW[7:4], 5) and s0 = min(SW[3:0], 9).
  - KEY[2] loads m1 = min(SW[7:4], 9) and m0 = min(SW[3:0], 9).
- Simultaneous pulses in one cycle: KEY[0] wins over KEY[2], and KEY[2] wins over KEY[1]. Only the winner acts.
- State machine (state type in package):
  - IDLE:
    - KEY[0] with time ≠ 00:00 → RUN, prescaler cleared to 0.
    - KEY[0] with time = 00:00 → stay in IDLE.
  - RUN:
    - KEY[0] → PAUSE.
    - On a tick, decrement the time.
    - If the decremented value is 00:00, go to DONE in the same edge.
  - PAUSE: KEY[0] → RUN. The prescaler holds its value and does not clear.
  - DONE: KEY[0] → IDLE. The time stays 00:00.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1 in RUN and DONE. It holds in PAUSE and is cleared in IDLE.
  - A tick is asserted in the cycle the count equals TICKS_PER_SEC-1. The count then wraps to 0.
- Decrement (BCD borrow chain):
  - s0: 0 → 9 with borrow, else s0-1.
  - s1 on borrow: 0 → 5 with borrow, else s1-1.
  - m0 on borrow: 0 → 9 with borrow, else m0-1.
  - m1 on borrow: m1-1. A borrow out of m1 is impossible because 00:00 never decrements.
- LEDR:
  - IDLE: 10'h000.
  - RUN: 10'h001.
  - PAUSE: 10'h002.
  - DONE: a `flash` flag set to 1 on entry and toggled on each tick. LEDR = flash ? 10'h3FF : 10'h000.
- HEX: each digit is decoded from the time registers. Digits 0–9 use the standard pattern; for example 0 = 7'b1000000 and 5 = 7'b0010010. Any non-BCD code shows blank, 7'h7F.

## Timing
- Reset (synchronous):
  - State IDLE, all digits 0, prescaler 0, flash 0, synchronizers 1 (released).
  - Outputs after the reset edge: LEDR = 0, HEX3..0 = 7'b1000000.
- Reset asserted mid-count or in DONE returns to the reset state at the next edge. Any key pulse in that cycle is dropped.
- Key latency: KEY first sampled low at edge n. The pulse is active between edges n+1 and n+2. The state/digit update is visible after edge n+2.
- HEX outputs are combinational from the registered digits. They change in the same cycle as the digits.
- LEDR is combinational from state and flash.
- The first decrement after IDLE→RUN occurs TICKS_PER_SEC edges after the start edge.
- PAUSE→RUN resumes from the held prescaler value, so the remaining fraction of the second is preserved.
- KEY[0] pulse coincident with a tick in RUN: the pause wins and no decrement occurs that cycle.
- Tick reaching 00:00: DONE, flash = 1, and LEDR = 10'h3FF are all visible after the same edge.

## Structure
- `egg_timer_pkg` holds:
  - the state enum IDLE/RUN/PAUSE/DONE;
  - the default TICKS_PER_SEC;
  - the seven-segment constants for 0–9 and blank.
- One sub-module, `seven_seg_decoder`: 4-bit BCD in, 7-bit active-low segments out, combinational. It is instantiated four times.
- Synchronizers, edge detect, prescaler, FSM and the BCD counter stay in `egg_timer_core`.

## Test plan
All scenarios use TICKS_PER_SEC = 4.
- Reset, then SW=8'h27 with a KEY[1] press, then SW=8'h01 with a KEY[2] press → HEX shows 01:27 and LEDR = 0. Repeat with SW=8'hFF on KEY[1] → 01:59 (clamped).
- From 01:00, KEY[0] → LEDR = 001. After 4 cycles the display reads 00:59 (borrow through s1 and m0). After a further 56 s (224 cycles) it reads 00:03.
- From 00:02 running: reaching 00:00 sets state DONE with LEDR = 3FF. LEDR then alternates 000/3FF every 4 cycles. A KEY[0] press → IDLE, LEDR = 0, HEX 00:00.
- Pause 2 cycles into a second, wait 20 cycles, then resume → the next decrement arrives exactly 2 cycles after resume. A KEY[1] press while paused loads; a KEY[1] press while running is ignored.
- KEY[0] and KEY[2] pressed in the same cycle in IDLE with time 00:05 → RUN starts and minutes are not loaded. KEY[0] in IDLE at 00:00 → stays IDLE.
- Reset asserted mid-RUN at 00:37 → after the next edge: IDLE, HEX 00:00, LEDR = 0. A key held through reset release generates no pulse.
